// File: rtl/aes_round_pipe_pkg.sv
// Shared AES definitions: column-major state matrix, MixColumns coefficients,
// GF(2^8) arithmetic, S-boxes and the per-stage payload carried down the round pipe.
package aes_round_pipe_pkg;

    localparam int AES_ROW    = 4;
    localparam int AES_COLUMN = 4;

    // Packed as [column][row][bit] so a 128-bit beat casts directly: s[r][c] = byte 4c+r.
    typedef logic [AES_COLUMN-1:0][AES_ROW-1:0][7:0] aes_matrix_t;

    localparam logic [7:0] MIX_FWD [AES_ROW][AES_COLUMN] = '{
        '{8'h02, 8'h03, 8'h01, 8'h01},
        '{8'h01, 8'h02, 8'h03, 8'h01},
        '{8'h01, 8'h01, 8'h02, 8'h03},
        '{8'h03, 8'h01, 8'h01, 8'h02}
    };

    localparam logic [7:0] MIX_INV [AES_ROW][AES_COLUMN] = '{
        '{8'h0e, 8'h0b, 8'h0d, 8'h09},
        '{8'h09, 8'h0e, 8'h0b, 8'h0d},
        '{8'h0d, 8'h09, 8'h0e, 8'h0b},
        '{8'h0b, 8'h0d, 8'h09, 8'h0e}
    };

    // Sideband user bits are kept beside this struct so TUSER_W stays a module parameter.
    typedef struct packed {
        aes_matrix_t matrix;
        aes_matrix_t key;
        logic        dec;
        logic        skip_mix;
        logic        last;
        logic        valid;
    } aes_stage_t;

    function automatic logic [7:0] gf_mult(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mult(p, p);
            r = gf_mult(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] s_box_f(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_s_box_f(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic aes_matrix_t sub_bytes_f(input aes_matrix_t m, input logic inv);
        aes_matrix_t o;
        for (int c = 0; c < AES_COLUMN; c++)
            for (int r = 0; r < AES_ROW; r++)
                o[c][r] = inv ? inv_s_box_f(m[c][r]) : s_box_f(m[c][r]);
        return o;
    endfunction

    function automatic aes_matrix_t shift_rows_f(input aes_matrix_t m, input logic inv);
        aes_matrix_t o;
        for (int c = 0; c < AES_COLUMN; c++)
            for (int r = 0; r < AES_ROW; r++)
                o[c][r] = inv ? m[(c + AES_COLUMN - r) % AES_COLUMN][r]
                              : m[(c + r) % AES_COLUMN][r];
        return o;
    endfunction

endpackage

// File: rtl/aes_round_pipe_mix.sv
// Combinational (Inv)MixColumns: each column multiplied by the forward or inverse
// coefficient matrix in GF(2^8), selected by inv_i.
module aes_mix_columns_unit
    import aes_round_pipe_pkg::*;
(
    input  aes_matrix_t state_i,
    input  logic        inv_i,
    output aes_matrix_t state_o
);

    always_comb begin
        state_o = '0;
        for (int c = 0; c < AES_COLUMN; c++)
            for (int r = 0; r < AES_ROW; r++)
                for (int k = 0; k < AES_ROW; k++)
                    state_o[c][r] = state_o[c][r] ^
                        gf_mult(inv_i ? MIX_INV[r][k] : MIX_FWD[r][k], state_i[c][k]);
    end

endmodule

// File: rtl/aes_round_pipe.sv
// Four-stage AES round engine, one forward or inverse round per beat, AXI-Stream in/out.
// Define AES_ROUND_DEC_EN to build the inverse datapath; otherwise tdec is ignored.
module aes_round_pipe
    import aes_round_pipe_pkg::*;
#(
    parameter int TUSER_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [127:0]       aes_in_tdata,
    input  logic [127:0]       aes_in_tkey,
    input  logic               aes_in_tdec,
    input  logic               aes_in_tskip_mix,
    input  logic [TUSER_W-1:0] aes_in_tuser,
    input  logic               aes_in_tlast,
    input  logic               aes_in_tvalid,
    output logic               aes_in_tready,
    output logic [127:0]       aes_out_tdata,
    output logic [TUSER_W-1:0] aes_out_tuser,
    output logic               aes_out_tlast,
    output logic               aes_out_tvalid,
    input  logic               aes_out_tready
);

`ifdef AES_ROUND_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam int NS = 4;

    aes_stage_t         st_q   [NS];
    aes_stage_t         st_d   [NS];
    logic [TUSER_W-1:0] user_q [NS];
    logic [TUSER_W-1:0] user_d [NS];
    logic               adv;
    logic               in_dec;
    aes_matrix_t        mix_s1;
    aes_matrix_t        mix_s2;

    // Whole pipe moves together: bubbles stay in place during a stall.
    assign adv           = !st_q[NS-1].valid || aes_out_tready;
    assign aes_in_tready = adv;
    assign in_dec        = DEC_EN && aes_in_tdec;

    generate
        if (DEC_EN) begin : g_inv_mix
            aes_mix_columns_unit u_mix_s1 (
                .state_i (st_q[0].matrix),
                .inv_i   (1'b1),
                .state_o (mix_s1)
            );
        end else begin : g_no_inv_mix
            assign mix_s1 = st_q[0].matrix;
        end
    endgenerate

    aes_mix_columns_unit u_mix_s2 (
        .state_i (st_q[1].matrix),
        .inv_i   (1'b0),
        .state_o (mix_s2)
    );

    always_comb begin
        st_d[0].key      = aes_in_tkey;
        st_d[0].dec      = in_dec;
        st_d[0].skip_mix = aes_in_tskip_mix;
        st_d[0].last     = aes_in_tlast;
        st_d[0].valid    = aes_in_tvalid;
        st_d[0].matrix   = in_dec ? (aes_in_tdata ^ aes_in_tkey)
                                  : sub_bytes_f(aes_in_tdata, 1'b0);
        user_d[0]        = aes_in_tuser;

        for (int i = 1; i < NS; i++) begin
            st_d[i]   = st_q[i-1];
            user_d[i] = user_q[i-1];
        end

        // S1: forward ShiftRows / inverse InvMix
        if (!st_q[0].dec)          st_d[1].matrix = shift_rows_f(st_q[0].matrix, 1'b0);
        else if (!st_q[0].skip_mix) st_d[1].matrix = mix_s1;

        // S2: forward Mix / inverse InvSubBytes
        if (st_q[1].dec)           st_d[2].matrix = sub_bytes_f(st_q[1].matrix, 1'b1);
        else if (!st_q[1].skip_mix) st_d[2].matrix = mix_s2;

        // S3: forward AddRoundKey / inverse InvShiftRows
        st_d[3].matrix = st_q[2].dec ? shift_rows_f(st_q[2].matrix, 1'b1)
                                     : (st_q[2].matrix ^ st_q[2].key);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NS; i++) begin
                st_q[i]   <= '0;
                user_q[i] <= '0;
            end
        end else if (adv) begin
            for (int i = 0; i < NS; i++) begin
                st_q[i]   <= st_d[i];
                user_q[i] <= user_d[i];
            end
        end
    end

    assign aes_out_tdata  = st_q[NS-1].matrix;
    assign aes_out_tuser  = user_q[NS-1];
    assign aes_out_tlast  = st_q[NS-1].last;
    assign aes_out_tvalid = st_q[NS-1].valid;

endmodule
